ddfs_multi_core: RTL and testbench
==================================

// Module: ddfs_multi_core
// PURPOSE
//  Time-multiplexed N-channel DDFS: one wavetable port and one interp/env datapath shared by NCH oscillators.
//  Each clken frame steps every enabled channel: phase accumulate, table read, linear interpolation, envelope scale.
//  The block mixes all channels into one sample. Sits between the bus register slot and the audio/DAC sample path.
// PARAMETERS
//  PW  32  phase accumulator / increment width
//  DW  16  sample and envelope width (signed; envelope is Q2.(DW-2))
//  AW  12  wavetable address width
//  FW  8   interpolation fraction width = phase bits [PW-AW-1 -: FW]
//  NCH 4   channel count (power of 2, >=2)
// PORTS
//  clk            in   1          clock
//  reset_n        in   1          asynchronous, active-low reset
//  clken          in   1          frame start strobe (sample rate)
//  data_interp    in   2x DW      table[hw_addr], table[hw_addr+1 mod 2^AW]; valid 1 cycle after hw_read
//  hw_addr        out  AW         wavetable address
//  hw_read        out  1          wavetable read strobe
//  cs,sw_read,sw_write in 1       bus select / read / write
//  sw_addr        in   $clog2(NCH)+3  {channel, reg[2:0]}
//  wr_data        in   PW         write data
//  rd_data        out  PW         read data, registered, 1-cycle latency
//  fOffset_ext    in   NCH x PW   per-channel external frequency offset
//  env_ext        in   NCH x DW   per-channel external envelope
//  sample_out     out  DW         mixed sample, held between frames
//  sample_valid   out  1          one-cycle pulse with a new sample_out
//  busy           out  1          frame in progress
// BEHAVIOUR
//  Reset: hw_addr=0, hw_read=0, rd_data=0, sample_out=0, sample_valid=0, busy=0; all phase accs 0;
//   fCarrier/fOffset/phOffset=0, env={2'b01,0..}(1.0), ctrl=0 (all channels disabled), overrun=0.
//  Reg map per channel: 0 fCarrier, 1 fOffset, 2 phOffset, 3 env[DW-1:0], 4 ctrl[2:0], 5 phase acc (RO),
//   6 status {overrun,busy} (global; any write clears overrun), 7 last sample_out (RO, zero-extended).
//  ctrl: b0 enable; b1 use fOffset_ext; b2 use env_ext. Write to RO reg ignored.
//  FSM IDLE->RUN on clken in IDLE; RUN issues channel c (0..NCH-1) in cycle c; DRAIN 4 cycles; ->IDLE.
//  clken sampled at edge E0: channel c hw_read high in cycle E0+1+c; sample_valid high in cycle E0+NCH+5.
//  busy high from E0+1 until sample_valid cycle inclusive; clken while busy ignored, sets overrun (sticky).
//  Slot c: addr/frac from (acc[c]+phOffset[c]); then acc[c] += fCarrier[c]+fOffset[c], mod 2^PW.
//  Disabled channel: hw_read low in its slot, acc held, contributes 0.
//  Pipe: data -> interp = s0 + (((s1-s0)*frac) >>> FW) (signed, DW+1 diff) -> env: (interp*env) >>> (DW-2),
//   truncated to DW -> accumulate in DW+$clog2(NCH) signed accumulator, cleared at frame start.
//  Register values sampled at slot issue; a write landing in the same cycle applies next frame.
//  Bus write and read in same cycle: read returns pre-write value.
//  Reset asserted mid-frame: all state to reset values immediately; no sample_valid for that frame.
// CONFIGURATION
//  DDFS_MIX_SAT_EN defined: mix result saturated to DW signed range (0x7FFF/0x8000 for DW=16).
//  Undefined: mix truncated to low DW bits (two's-complement wrap).
// TESTING
//  Reset: hold reset_n low, release -> hw_read=0, sample_valid=0; read ch0 reg3 -> 0x4000.
//  ch0 en, fCarrier=0x00080000, env=0x4000, table[i]=16*i -> samples 0,8,16,24,...; hw_addr 0,0,1,1,...
//  ch0 acc preset by fCarrier steps to 0xFFF00000, step 0x00100000 -> hw_addr 0xFFF then 0x000, acc wraps to 0.
//  clken at E0, again at E0+2 -> second ignored, status=0b11; write reg6 -> overrun 0; sample_valid once at E0+NCH+5.
//  4 ch en, table constant 0x7000, env 1.0 -> SAT_EN: sample_out 0x7FFF; without: 0xC000.
//  reset_n low at E0+3 -> hw_read, busy, sample_valid 0 at once; no sample_valid until next clken.

Source files
------------

// File: rtl/ddfs_multi_core.sv
// Time-multiplexed NCH-channel DDFS sharing one wavetable port and one interp/envelope datapath.
// Build option: define DDFS_MIX_SAT_EN to saturate the channel mix instead of wrapping it.
module ddfs_multi_core #(
   parameter int PW  = 32,
   parameter int DW  = 16,
   parameter int AW  = 12,
   parameter int FW  = 8,
   parameter int NCH = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    clken,
   input  logic [2*DW-1:0]         data_interp,
   output logic [AW-1:0]           hw_addr,
   output logic                    hw_read,
   input  logic                    cs,
   input  logic                    sw_read,
   input  logic                    sw_write,
   input  logic [$clog2(NCH)+2:0]  sw_addr,
   input  logic [PW-1:0]           wr_data,
   output logic [PW-1:0]           rd_data,
   input  logic [NCH*PW-1:0]       fOffset_ext,
   input  logic [NCH*DW-1:0]       env_ext,
   output logic [DW-1:0]           sample_out,
   output logic                    sample_valid,
   output logic                    busy
);
   localparam int CW = $clog2(NCH);
   localparam int MW = DW + CW;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    slot_q, slot_d;
   logic [1:0]       drain_q, drain_d;
   logic             issue_s, last_s, accept_s;

   logic [PW-1:0]    acc_q [NCH];
   logic [PW-1:0]    fcar_q [NCH];
   logic [PW-1:0]    foff_q [NCH];
   logic [PW-1:0]    phoff_q [NCH];
   logic [DW-1:0]    env_q [NCH];
   logic [2:0]       ctrl_q [NCH];
   logic             overrun_q, busy_q;

   logic [AW-1:0]    addr_q;
   logic             v1_q, v2_q, v3_q, v4_q;
   logic             l1_q, l2_q, l3_q, l4_q, l5_q;
   logic [FW-1:0]    frac1_q, frac2_q;
   logic [DW-1:0]    env1_q, env2_q, env3_q;
   logic [DW-1:0]    interp3_q, prod4_q, sample_q;
   logic [MW-1:0]    mix_q;
   logic             valid_q;
   logic [PW-1:0]    rd_q;

   logic [PW-1:0]    phase_s, inc_s;
   logic [DW-1:0]    env_sel_s;
   logic signed [DW:0]       diff_s;
   logic signed [DW+FW+1:0]  ip_prod_s, ip_sum_s;
   logic signed [2*DW-1:0]   env_prod_s;
   logic [CW-1:0]    bus_ch_s;
   logic [2:0]       bus_reg_s;
   logic [PW-1:0]    rd_mux_s;

   function automatic logic [DW-1:0] mix_out(input logic [MW-1:0] m);
`ifdef DDFS_MIX_SAT_EN
      if (!m[MW-1] && (m[MW-2:DW-1] != {(MW-DW){1'b0}}))
         return {1'b0, {(DW-1){1'b1}}};
      else if (m[MW-1] && (m[MW-2:DW-1] != {(MW-DW){1'b1}}))
         return {1'b1, {(DW-1){1'b0}}};
      else
         return m[DW-1:0];
`else
      return m[DW-1:0];
`endif
   endfunction

   assign accept_s  = clken && (state_q == S_IDLE) && !busy_q;
   assign bus_ch_s  = sw_addr[CW+2:3];
   assign bus_reg_s = sw_addr[2:0];

   // Frame sequencer state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         slot_q  <= {CW{1'b0}};
         drain_q <= 2'd0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         drain_q <= drain_d;
      end
   end

   // Frame sequencer next state: one slot per channel, then let the pipe drain.
   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      drain_d = drain_q;
      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               state_d = S_RUN;
               slot_d  = {CW{1'b0}};
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (slot_q == CW'(NCH-1)) begin
               state_d = S_DRAIN;
               drain_d = 2'd0;
            end else begin
               slot_d = slot_q + {{(CW-1){1'b0}}, 1'b1};
            end
         end
         S_DRAIN: begin
            if (drain_q == 2'd3) state_d = S_IDLE;
            else                 drain_d = drain_q + 2'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Frame sequencer outputs.
   always_comb begin
      issue_s = (state_q == S_RUN);
      last_s  = issue_s && (slot_q == CW'(NCH-1));
   end

   // Per-slot operand selection (register values seen at issue time).
   always_comb begin
      phase_s   = acc_q[slot_q] + phoff_q[slot_q];
      inc_s     = fcar_q[slot_q] + (ctrl_q[slot_q][1] ? fOffset_ext[slot_q*PW +: PW] : foff_q[slot_q]);
      env_sel_s = ctrl_q[slot_q][2] ? env_ext[slot_q*DW +: DW] : env_q[slot_q];
   end

   // Interpolation and envelope arithmetic.
   always_comb begin
      diff_s     = $signed({data_interp[2*DW-1], data_interp[2*DW-1:DW]})
                 - $signed({data_interp[DW-1], data_interp[DW-1:0]});
      ip_prod_s  = diff_s * $signed({1'b0, frac2_q});
      ip_sum_s   = $signed({{(FW+2){data_interp[DW-1]}}, data_interp[DW-1:0]}) + (ip_prod_s >>> FW);
      env_prod_s = $signed(interp3_q) * $signed(env3_q);
   end

   // Phase accumulators and bus-writable channel registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NCH; i++) begin
            acc_q[i]   <= {PW{1'b0}};
            fcar_q[i]  <= {PW{1'b0}};
            foff_q[i]  <= {PW{1'b0}};
            phoff_q[i] <= {PW{1'b0}};
            env_q[i]   <= {2'b01, {(DW-2){1'b0}}};
            ctrl_q[i]  <= 3'b000;
         end
      end else begin
         if (issue_s && ctrl_q[slot_q][0]) acc_q[slot_q] <= acc_q[slot_q] + inc_s;
         if (cs && sw_write) begin
            case (bus_reg_s)
               3'd0:    fcar_q[bus_ch_s]  <= wr_data;
               3'd1:    foff_q[bus_ch_s]  <= wr_data;
               3'd2:    phoff_q[bus_ch_s] <= wr_data;
               3'd3:    env_q[bus_ch_s]   <= wr_data[DW-1:0];
               3'd4:    ctrl_q[bus_ch_s]  <= wr_data[2:0];
               default: ;
            endcase
         end
      end
   end

   // Sample pipeline: issue, table latency, interpolate, envelope, mix, publish.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q    <= {AW{1'b0}};
         v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0; v4_q <= 1'b0;
         l1_q <= 1'b0; l2_q <= 1'b0; l3_q <= 1'b0; l4_q <= 1'b0; l5_q <= 1'b0;
         frac1_q   <= {FW{1'b0}};
         frac2_q   <= {FW{1'b0}};
         env1_q    <= {DW{1'b0}};
         env2_q    <= {DW{1'b0}};
         env3_q    <= {DW{1'b0}};
         interp3_q <= {DW{1'b0}};
         prod4_q   <= {DW{1'b0}};
         mix_q     <= {MW{1'b0}};
         sample_q  <= {DW{1'b0}};
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         v1_q <= issue_s && ctrl_q[slot_q][0];
         l1_q <= last_s;
         if (issue_s && ctrl_q[slot_q][0]) begin
            addr_q  <= phase_s[PW-1 -: AW];
            frac1_q <= phase_s[PW-AW-1 -: FW];
            env1_q  <= env_sel_s;
         end
         v2_q <= v1_q;  l2_q <= l1_q;  frac2_q <= frac1_q;  env2_q <= env1_q;
         v3_q <= v2_q;  l3_q <= l2_q;  env3_q  <= env2_q;
         interp3_q <= ip_sum_s[DW-1:0];
         v4_q <= v3_q;  l4_q <= l3_q;
         prod4_q <= env_prod_s[DW-2 +: DW];
         l5_q <= l4_q;
         if (accept_s)  mix_q <= {MW{1'b0}};
         else if (v4_q) mix_q <= mix_q + {{CW{prod4_q[DW-1]}}, prod4_q};
         if (l5_q) sample_q <= mix_out(mix_q);
         valid_q <= l5_q;
         busy_q  <= (state_q != S_IDLE) || l1_q || l2_q || l3_q || l4_q || l5_q;
      end
   end

   // Bus read mux; reads see pre-write register contents.
   always_comb begin
      case (bus_reg_s)
         3'd0:    rd_mux_s = fcar_q[bus_ch_s];
         3'd1:    rd_mux_s = foff_q[bus_ch_s];
         3'd2:    rd_mux_s = phoff_q[bus_ch_s];
         3'd3:    rd_mux_s = {{(PW-DW){1'b0}}, env_q[bus_ch_s]};
         3'd4:    rd_mux_s = {{(PW-3){1'b0}}, ctrl_q[bus_ch_s]};
         3'd5:    rd_mux_s = acc_q[bus_ch_s];
         3'd6:    rd_mux_s = {{(PW-2){1'b0}}, overrun_q, busy_q};
         3'd7:    rd_mux_s = {{(PW-DW){1'b0}}, sample_q};
         default: rd_mux_s = {PW{1'b0}};
      endcase
   end

   // Read data register and sticky frame-overrun flag (a new overrun beats a clear).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_q      <= {PW{1'b0}};
         overrun_q <= 1'b0;
      end else begin
         if (cs && sw_read) rd_q <= rd_mux_s;
         if (clken && !accept_s)                          overrun_q <= 1'b1;
         else if (cs && sw_write && bus_reg_s == 3'd6)    overrun_q <= 1'b0;
      end
   end

   assign hw_addr      = addr_q;
   assign hw_read      = v1_q;
   assign rd_data      = rd_q;
   assign sample_out   = sample_q;
   assign sample_valid = valid_q;
   assign busy         = busy_q;
endmodule

// File: tb/tb_ddfs_multi_core.sv
// Directed self-checking bench for ddfs_multi_core with a registered wavetable model.
module tb_ddfs_multi_core;
   logic        clk = 1'b0;
   logic        reset_n, clken, cs, sw_read, sw_write;
   logic [31:0] data_interp;
   logic [11:0] hw_addr;
   logic        hw_read;
   logic [4:0]  sw_addr;
   logic [31:0] wr_data, rd_data;
   logic [127:0] fOffset_ext;
   logic [63:0] env_ext;
   logic [15:0] sample_out;
   logic        sample_valid, busy;
   logic        tmode;   // 0: ramp table 16*i, 1: constant 0x7000
   int          errors = 0;
   int          checks = 0;

   ddfs_multi_core dut (
      .clk(clk), .reset_n(reset_n), .clken(clken), .data_interp(data_interp),
      .hw_addr(hw_addr), .hw_read(hw_read), .cs(cs), .sw_read(sw_read), .sw_write(sw_write),
      .sw_addr(sw_addr), .wr_data(wr_data), .rd_data(rd_data), .fOffset_ext(fOffset_ext),
      .env_ext(env_ext), .sample_out(sample_out), .sample_valid(sample_valid), .busy(busy));

   always #5 clk = ~clk;

   function automatic logic [15:0] tbl(input logic [11:0] a);
      logic [15:0] v;
      v = {a, 4'h0};
      return tmode ? 16'h7000 : v;
   endfunction

   always @(posedge clk) begin
      if (hw_read) data_interp <= {tbl(hw_addr + 12'd1), tbl(hw_addr)};
   end

   task automatic bus_wr(input logic [1:0] ch, input logic [2:0] rg, input logic [31:0] d);
      @(negedge clk); cs = 1'b1; sw_write = 1'b1; sw_addr = {ch, rg}; wr_data = d;
      @(negedge clk); cs = 1'b0; sw_write = 1'b0;
   endtask

   task automatic bus_rd(input logic [1:0] ch, input logic [2:0] rg, output logic [31:0] d);
      @(negedge clk); cs = 1'b1; sw_read = 1'b1; sw_addr = {ch, rg};
      @(negedge clk); cs = 1'b0; sw_read = 1'b0; d = rd_data;
   endtask

   task automatic do_reset();
      reset_n = 1'b0; clken = 1'b0; cs = 1'b0; sw_read = 1'b0; sw_write = 1'b0;
      sw_addr = 5'd0; wr_data = 32'd0; fOffset_ext = 128'd0; env_ext = 64'd0;
      data_interp = 32'd0; tmode = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   // One frame: returns first sample_valid cycle after E0, pulse count, ch0 slot addr/read, ch1 slot read.
   task automatic frame(output int vcyc, output int nval, output logic [11:0] a0,
                        output logic r0, output logic r1);
      @(negedge clk); clken = 1'b1;
      @(posedge clk); #1; clken = 1'b0;
      vcyc = -1; nval = 0; a0 = 12'd0; r0 = 1'b0; r1 = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (k == 1) begin a0 = hw_addr; r0 = hw_read; end
         if (k == 2) r1 = hw_read;
         if (sample_valid) begin
            nval++;
            if (vcyc < 0) vcyc = k;
         end
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      do_reset();
      checks++; if (hw_read !== 1'b0) begin errors++; $display("FAIL reset_hw_read got=%b exp=0", hw_read); end
      checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", sample_valid); end
      checks++; if (busy !== 1'b0 || sample_out !== 16'h0) begin errors++; $display("FAIL reset_busy_out got=%b/%h exp=0/0000", busy, sample_out); end
      bus_rd(2'd0, 3'd3, d);
      checks++; if (d !== 32'h4000) begin errors++; $display("FAIL reset_env got=%h exp=00004000", d); end
      bus_rd(2'd2, 3'd4, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl got=%h exp=0", d); end
   endtask

   task automatic test_ramp();
      int vc, nv; logic [11:0] a0; logic r0, r1; logic [31:0] d;
      logic [15:0] exp_s [4] = '{16'd0, 16'd8, 16'd16, 16'd24};
      logic [11:0] exp_a [4] = '{12'd0, 12'd0, 12'd1, 12'd1};
      do_reset();
      bus_wr(2'd0, 3'd0, 32'h0008_0000);
      bus_wr(2'd0, 3'd4, 32'h1);
      bus_rd(2'd0, 3'd0, d);
      checks++; if (d !== 32'h0008_0000) begin errors++; $display("FAIL ramp_fcar_rb got=%h exp=00080000", d); end
      for (int f = 0; f < 4; f++) begin
         frame(vc, nv, a0, r0, r1);
         checks++; if (sample_out !== exp_s[f]) begin errors++; $display("FAIL ramp_sample[%0d] got=%h exp=%h", f, sample_out, exp_s[f]); end
         checks++; if (a0 !== exp_a[f] || r0 !== 1'b1) begin errors++; $display("FAIL ramp_addr[%0d] got=%h/%b exp=%h/1", f, a0, r0, exp_a[f]); end
         checks++; if (vc !== 9 || nv !== 1) begin errors++; $display("FAIL ramp_valid_timing[%0d] got=%0d/%0d exp=9/1", f, vc, nv); end
         checks++; if (r1 !== 1'b0) begin errors++; $display("FAIL ramp_ch1_disabled[%0d] got=%b exp=0", f, r1); end
      end
      bus_rd(2'd0, 3'd5, d);
      checks++; if (d !== 32'h0020_0000) begin errors++; $display("FAIL ramp_acc got=%h exp=00200000", d); end
      bus_rd(2'd0, 3'd7, d);
      checks++; if (d !== 32'h18) begin errors++; $display("FAIL ramp_last_sample got=%h exp=00000018", d); end
   endtask

   task automatic test_wrap();
      int vc, nv; logic [11:0] a0; logic r0, r1; logic [31:0] d;
      do_reset();
      bus_wr(2'd0, 3'd0, 32'hFFF0_0000);
      bus_wr(2'd0, 3'd4, 32'h1);
      frame(vc, nv, a0, r0, r1);
      checks++; if (a0 !== 12'h000) begin errors++; $display("FAIL wrap_addr0 got=%h exp=000", a0); end
      bus_wr(2'd0, 3'd0, 32'h0010_0000);
      frame(vc, nv, a0, r0, r1);
      checks++; if (a0 !== 12'hFFF) begin errors++; $display("FAIL wrap_addr_top got=%h exp=fff", a0); end
      checks++; if (sample_out !== 16'hFFF0) begin errors++; $display("FAIL wrap_sample got=%h exp=fff0", sample_out); end
      bus_rd(2'd0, 3'd5, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL wrap_acc got=%h exp=0", d); end
      frame(vc, nv, a0, r0, r1);
      checks++; if (a0 !== 12'h000) begin errors++; $display("FAIL wrap_addr_after got=%h exp=000", a0); end
   endtask

   task automatic test_ext();
      int vc, nv; logic [11:0] a0; logic r0, r1; logic [31:0] d;
      do_reset();
      fOffset_ext[31:0] = 32'h0010_0000;
      env_ext[15:0]     = 16'h2000;
      bus_wr(2'd0, 3'd1, 32'h0000_0007);
      bus_wr(2'd0, 3'd2, 32'h0030_0000);
      bus_wr(2'd0, 3'd4, 32'h7);
      frame(vc, nv, a0, r0, r1);
      checks++; if (a0 !== 12'd3 || sample_out !== 16'd24) begin errors++; $display("FAIL ext_frame1 got=%h/%h exp=003/0018", a0, sample_out); end
      bus_rd(2'd0, 3'd5, d);
      checks++; if (d !== 32'h0010_0000) begin errors++; $display("FAIL ext_acc got=%h exp=00100000", d); end
      frame(vc, nv, a0, r0, r1);
      checks++; if (a0 !== 12'd4 || sample_out !== 16'd32) begin errors++; $display("FAIL ext_frame2 got=%h/%h exp=004/0020", a0, sample_out); end
   endtask

   task automatic test_overrun();
      int nv, vc; logic [31:0] d;
      do_reset();
      bus_wr(2'd0, 3'd4, 32'h1);
      @(negedge clk); clken = 1'b1;
      @(posedge clk); #1; clken = 1'b0;
      nv = 0; vc = -1; d = 32'hDEAD;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (sample_valid) begin nv++; if (vc < 0) vc = k; end
         if (k == 1) clken = 1'b1;
         if (k == 2) begin clken = 1'b0; cs = 1'b1; sw_read = 1'b1; sw_addr = {2'd0, 3'd6}; end
         if (k == 3) begin cs = 1'b0; sw_read = 1'b0; d = rd_data; end
      end
      checks++; if (d !== 32'h3) begin errors++; $display("FAIL overrun_status got=%h exp=3", d); end
      checks++; if (nv !== 1 || vc !== 9) begin errors++; $display("FAIL overrun_valid got=%0d@%0d exp=1@9", nv, vc); end
      bus_wr(2'd3, 3'd6, 32'h0);
      bus_rd(2'd0, 3'd6, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL overrun_clear got=%h exp=0", d); end
   endtask

   task automatic test_mix();
      int vc, nv; logic [11:0] a0; logic r0, r1; logic [31:0] d;
      logic [15:0] exp_mix;
`ifdef DDFS_MIX_SAT_EN
      exp_mix = 16'h7FFF;
`else
      exp_mix = 16'hC000;
`endif
      do_reset();
      tmode = 1'b1;
      for (int c = 0; c < 4; c++) bus_wr(2'(c), 3'd4, 32'h1);
      frame(vc, nv, a0, r0, r1);
      checks++; if (sample_out !== exp_mix) begin errors++; $display("FAIL mix_sample got=%h exp=%h", sample_out, exp_mix); end
      checks++; if (r1 !== 1'b1) begin errors++; $display("FAIL mix_ch1_read got=%b exp=1", r1); end
      bus_rd(2'd1, 3'd7, d);
      checks++; if (d !== {16'h0, exp_mix}) begin errors++; $display("FAIL mix_reg7 got=%h exp=%h", d, exp_mix); end
   endtask

   task automatic test_reset_midframe();
      int nv; logic [31:0] d; logic hr;
      @(negedge clk); clken = 1'b1;
      @(posedge clk); #1; clken = 1'b0;
      repeat (3) @(posedge clk);
      #1; hr = hw_read;
      checks++; if (hr !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL midrst_pre got=%b/%b exp=1/1", hr, busy); end
      reset_n = 1'b0;
      #1;
      checks++; if (hw_read !== 1'b0 || busy !== 1'b0 || sample_valid !== 1'b0) begin
         errors++; $display("FAIL midrst_async got=%b/%b/%b exp=0/0/0", hw_read, busy, sample_valid); end
      @(negedge clk); reset_n = 1'b1;
      nv = 0;
      for (int k = 0; k < 20; k++) begin @(posedge clk); #1; if (sample_valid) nv++; end
      checks++; if (nv !== 0) begin errors++; $display("FAIL midrst_no_valid got=%0d exp=0", nv); end
      bus_rd(2'd0, 3'd4, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL midrst_ctrl got=%h exp=0", d); end
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_wrap();
      test_ext();
      test_overrun();
      test_mix();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
